// File: rtl/bundle2cols_stream_if.sv
// Handshake bundle for bundle2cols_stream: one-shot bundle input, column-beat output stream.
interface bundle2cols_stream_if #(
    parameter int d     = 1,
    parameter int Nbits = 128,
    parameter int COLS  = 1
);
    localparam int NB   = Nbits / (4 * COLS);
    localparam int IDXW = (NB > 1) ? $clog2(NB) : 1;

    logic                    in_valid;
    logic                    in_ready;
    logic [Nbits*d-1:0]      bundle_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [4*d*COLS-1:0]     out_cols;
    logic [IDXW-1:0]         out_idx;
    logic                    out_last;

    modport master (
        output in_valid, bundle_in, out_ready,
        input  in_ready, out_valid, out_cols, out_idx, out_last
    );

    modport slave (
        input  in_valid, bundle_in, out_ready,
        output in_ready, out_valid, out_cols, out_idx, out_last
    );
endinterface

// File: rtl/bundle2cols_stream.sv
// Serializes one masked bundle into column beats of COLS columns x 4 rows x d shares.
// Optional abort input enabled by defining BUNDLE2COLS_STREAM_ABORT_EN.
module bundle2cols_stream #(
    parameter int d     = 1,
    parameter int Nbits = 128,
    parameter int COLS  = 1
) (
    input  logic clk,
    input  logic rst_n,
`ifdef BUNDLE2COLS_STREAM_ABORT_EN
    input  logic abort,
`endif
    bundle2cols_stream_if.slave bus
);
    localparam int Q    = Nbits / 4;
    localparam int NB   = Nbits / (4 * COLS);
    localparam int IDXW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NB - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state_q, state_d;
    logic [IDXW-1:0]      cnt_q, cnt_d;
    logic [Nbits*d-1:0]   buf_q, buf_d;
    logic                 last;
    logic                 abort_req;
    logic [4*d*COLS-1:0]  cols_raw;

`ifdef BUNDLE2COLS_STREAM_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    // Buffer is wiped whenever a transfer ends so shares never linger in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = SEND;
                    cnt_d   = '0;
                    buf_d   = bus.bundle_in;
                end
            end
            SEND: begin
                if (abort_req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    buf_d   = '0;
                end else if (bus.out_ready) begin
                    if (last) begin
                        state_d = IDLE;
                        buf_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign last          = (state_q == SEND) && (cnt_q == LAST_IDX);
    assign bus.in_ready  = rst_n && (state_q == IDLE);
    assign bus.out_valid = (state_q == SEND);
    assign bus.out_last  = last;
    assign bus.out_idx   = cnt_q;

    // Each share/row slice is shifted down to the current beat's first column.
    for (genvar j = 0; j < d; j++) begin : g_share
        for (genvar r = 0; r < 4; r++) begin : g_row
            logic [Q-1:0] row_vec;
            logic [Q-1:0] row_sh;
            assign row_vec = buf_q[j*Nbits + r*Q +: Q];
            assign row_sh  = row_vec >> (32'(cnt_q) * COLS);
            for (genvar k = 0; k < COLS; k++) begin : g_col
                assign cols_raw[k*4*d + 4*j + r] = row_sh[k];
            end
        end
    end

    assign bus.out_cols = (state_q == SEND) ? cols_raw : '0;
endmodule

// File: tb/tb_bundle2cols_stream.sv
// Self-checking bench for bundle2cols_stream: directed table, corner sequences and random traffic.
module tb_bundle2cols_stream;
    logic clk = 1'b0;
    logic rst_n;
`ifdef BUNDLE2COLS_STREAM_ABORT_EN
    logic abort;
`endif
    always #5 clk = ~clk;

    bundle2cols_stream_if #(.d(1), .Nbits(128), .COLS(1)) bus_a ();
    bundle2cols_stream_if #(.d(2), .Nbits(128), .COLS(2)) bus_b ();

    bundle2cols_stream #(.d(1), .Nbits(128), .COLS(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef BUNDLE2COLS_STREAM_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus_a)
    );

    bundle2cols_stream #(.d(2), .Nbits(128), .COLS(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef BUNDLE2COLS_STREAM_ABORT_EN
        .abort (1'b0),
`endif
        .bus   (bus_b)
    );

    int total = 0;
    int bad   = 0;
    logic [3:0]  seen_a [32];
    logic [15:0] seen_b [16];

    typedef struct {
        logic [127:0] bundle;
        int           idx;
        logic [3:0]   cols;
    } vec_t;
    vec_t vecs [7];

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic iv, input logic [127:0] b, input logic ordy);
        bus_a.in_valid  = iv;
        bus_a.bundle_in = b;
        bus_a.out_ready = ordy;
    endtask

    // Column c of share 0: row r sits at bit r*32 + c.
    function automatic logic [3:0] model_a(input logic [127:0] b, input int c);
        logic [3:0] m;
        for (int r = 0; r < 4; r++) m[r] = b[r*32 + c];
        return m;
    endfunction

    function automatic logic [15:0] model_b(input logic [255:0] b, input int beat);
        logic [15:0] m;
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 2; j++)
                for (int r = 0; r < 4; r++)
                    m[k*8 + j*4 + r] = b[j*128 + r*32 + beat*2 + k];
        return m;
    endfunction

    // mode 0: always ready; 1: random ready + in_valid noise; 2: two stalls on beat 5;
    // 3: return while beat stop_at is presented (caller continues).
    task automatic run_a(input logic [127:0] b, input int mode, input int stop_at);
        int e = 0;
        int cyc = 0;
        int hold5 = 0;
        logic r;
        bit done = 0;
        while (!bus_a.in_ready && cyc < 50) begin
            step();
            cyc++;
        end
        checkOutput("a_in_ready_idle", 32'(bus_a.in_ready), 1);
        checkOutput("a_out_cols_idle", 32'(bus_a.out_cols), 0);
        applyStimulus(1'b1, b, 1'b0);
        step();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("a_out_valid_first", 32'(bus_a.out_valid), 1);
        checkOutput("a_in_ready_send", 32'(bus_a.in_ready), 0);
        cyc = 0;
        while (!done && cyc < 400) begin
            if (mode == 3 && e == stop_at) begin
                checkOutput("a_stop_idx", 32'(bus_a.out_idx), 32'(e));
                return;
            end
            r = 1'b1;
            if (mode == 1) begin
                r = 1'($urandom_range(0, 1));
                bus_a.in_valid  = 1'($urandom_range(0, 1));
                bus_a.bundle_in = {$urandom, $urandom, $urandom, $urandom};
            end else if (mode == 2 && e == 5 && hold5 < 2) begin
                r = 1'b0;
            end
            bus_a.out_ready = r;
            checkOutput("a_out_valid", 32'(bus_a.out_valid), 1);
            checkOutput("a_out_idx", 32'(bus_a.out_idx), 32'(e));
            checkOutput("a_out_cols", 32'(bus_a.out_cols), 32'(model_a(b, e)));
            checkOutput("a_out_last", 32'(bus_a.out_last), 32'(e == 31));
            if (e == 5) hold5++;
            if (r) begin
                seen_a[e] = bus_a.out_cols;
                if (e == 31) done = 1;
                e++;
            end
            step();
            cyc++;
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("a_beats_transferred", 32'(e), 32);
        if (mode == 2) checkOutput("a_stall_hold_cycles", 32'(hold5), 3);
        checkOutput("a_out_valid_after", 32'(bus_a.out_valid), 0);
        checkOutput("a_in_ready_after", 32'(bus_a.in_ready), 1);
        checkOutput("a_out_cols_after", 32'(bus_a.out_cols), 0);
        checkOutput("a_out_last_after", 32'(bus_a.out_last), 0);
    endtask

    task automatic run_b(input logic [255:0] b, input bit rnd);
        int e = 0;
        int cyc = 0;
        logic r;
        bit done = 0;
        checkOutput("b_in_ready_idle", 32'(bus_b.in_ready), 1);
        bus_b.in_valid  = 1'b1;
        bus_b.bundle_in = b;
        bus_b.out_ready = 1'b0;
        step();
        bus_b.in_valid = 1'b0;
        while (!done && cyc < 200) begin
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus_b.out_ready = r;
            checkOutput("b_out_valid", 32'(bus_b.out_valid), 1);
            checkOutput("b_out_idx", 32'(bus_b.out_idx), 32'(e));
            checkOutput("b_out_cols", 32'(bus_b.out_cols), 32'(model_b(b, e)));
            checkOutput("b_out_last", 32'(bus_b.out_last), 32'(e == 15));
            if (r) begin
                seen_b[e] = bus_b.out_cols;
                if (e == 15) done = 1;
                e++;
            end
            step();
            cyc++;
        end
        bus_b.out_ready = 1'b0;
        checkOutput("b_beats_transferred", 32'(e), 16);
        checkOutput("b_out_valid_after", 32'(bus_b.out_valid), 0);
        checkOutput("b_out_cols_after", 32'(bus_b.out_cols), 0);
    endtask

    initial begin
        logic [127:0] pat2;
        logic [255:0] bb;
        pat2 = '0;
        pat2[32] = 1'b1;
        pat2[64] = 1'b1;
        pat2[96] = 1'b1;
        pat2[31] = 1'b1;
        vecs[0] = '{128'h1, 0, 4'h1};
        vecs[1] = '{128'h1, 5, 4'h0};
        vecs[2] = '{128'h1, 31, 4'h0};
        vecs[3] = '{pat2, 0, 4'hE};
        vecs[4] = '{pat2, 31, 4'h1};
        vecs[5] = '{pat2, 17, 4'h0};
        vecs[6] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000, 31, 4'h8};

        rst_n = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        bus_b.in_valid  = 1'b0;
        bus_b.bundle_in = '0;
        bus_b.out_ready = 1'b0;
`ifdef BUNDLE2COLS_STREAM_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) step();
        checkOutput("rst_in_ready_low", 32'(bus_a.in_ready), 0);
        checkOutput("rst_out_valid", 32'(bus_a.out_valid), 0);
        checkOutput("rst_out_cols", 32'(bus_a.out_cols), 0);
        checkOutput("rst_out_idx", 32'(bus_a.out_idx), 0);
        checkOutput("rst_out_last", 32'(bus_a.out_last), 0);
        rst_n = 1'b1;
        step();
        checkOutput("rst_in_ready_after", 32'(bus_a.in_ready), 1);

        $display("[TB] directed table");
        for (int i = 0; i < 7; i++) begin
            run_a(vecs[i].bundle, 0, 0);
            checkOutput("table_beat", 32'(seen_a[vecs[i].idx]), 32'(vecs[i].cols));
            step();
        end

        $display("[TB] backpressure on beat 5");
        run_a({$urandom, $urandom, $urandom, $urandom}, 2, 0);
        step();

        $display("[TB] random traffic");
        for (int i = 0; i < 4; i++) begin
            run_a({$urandom, $urandom, $urandom, $urandom}, 1, 0);
            step();
        end

        $display("[TB] reset mid-transfer");
        run_a({$urandom, $urandom, $urandom, $urandom} | 128'h1, 3, 10);
        rst_n = 1'b0;
        bus_a.out_ready = 1'b1;
        step();
        checkOutput("midrst_out_valid", 32'(bus_a.out_valid), 0);
        checkOutput("midrst_out_cols", 32'(bus_a.out_cols), 0);
        checkOutput("midrst_out_idx", 32'(bus_a.out_idx), 0);
        checkOutput("midrst_in_ready", 32'(bus_a.in_ready), 0);
        rst_n = 1'b1;
        bus_a.out_ready = 1'b0;
        step();
        checkOutput("midrst_in_ready_release", 32'(bus_a.in_ready), 1);
        run_a(128'h1, 0, 0);
        checkOutput("midrst_restart_beat0", 32'(seen_a[0]), 1);
        step();

`ifdef BUNDLE2COLS_STREAM_ABORT_EN
        $display("[TB] abort");
        run_a({$urandom, $urandom, $urandom, $urandom}, 3, 3);
        abort = 1'b1;
        bus_a.out_ready = 1'b1;
        step();
        abort = 1'b0;
        bus_a.out_ready = 1'b0;
        checkOutput("abort_out_valid", 32'(bus_a.out_valid), 0);
        checkOutput("abort_in_ready", 32'(bus_a.in_ready), 1);
        checkOutput("abort_out_idx", 32'(bus_a.out_idx), 0);
        checkOutput("abort_out_cols", 32'(bus_a.out_cols), 0);
        abort = 1'b1;
        applyStimulus(1'b1, 128'h2, 1'b0);
        step();
        abort = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("abort_idle_accept", 32'(bus_a.out_valid), 1);
        checkOutput("abort_idle_beat0", 32'(bus_a.out_cols), 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        run_a(pat2, 0, 0);
        step();
`endif

        $display("[TB] two shares, two columns per beat");
        bb = {128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'h1};
        run_b(bb, 1'b0);
        checkOutput("b_beat0", 32'(seen_b[0]), 32'h0001);
        checkOutput("b_beat15", 32'(seen_b[15]), 32'h8000);
        step();
        for (int i = 0; i < 3; i++) begin
            run_b({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bundle2cols_stream.md
Name: bundle2cols_stream

Overview:
- Sequential converter from bundle representation to column representation for masked Shadow-512 state slices.
- Accepts one full shared bundle in a single handshake, then streams it out as column beats.
- Each beat carries COLS columns, each column holding 4 bits per share.
- Sits between the bundle-domain datapath (e.g. the S-box layer) and column-domain consumers (e.g. the L-box/column logic); it is the serializing counterpart of the column-to-bundle regrouping.

Parameters:
- d, 1, number of masking shares
- Nbits, 128, state bits per share; multiple of 4
- COLS, 1, columns emitted per output beat; must divide Nbits/4

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  bundle_in is valid
- in_ready  output  1  block can accept a bundle
- bundle_in  input  Nbits*d  shared bundle; bit j*Nbits + r*(Nbits/4) + i = share j, row r, column i
- out_valid  output  1  out_cols holds a valid beat
- out_ready  input  1  consumer accepts the beat
- out_cols  output  4*d*COLS  column beat; bit k*4*d + 4*j + r = share j, row r, column (base+k)
- out_idx  output  log2(Nbits/(4*COLS)) (min 1)  beat index, 0 = columns 0..COLS-1
- out_last  output  1  high on the final beat of a bundle

Behaviour:
- State machine:
  - IDLE: in_ready=1, out_valid=0.
  - SEND: in_ready=0, out_valid=1.
  - IDLE -> SEND on in_valid & in_ready; bundle_in is captured into the internal buffer and beat counter cnt is set to 0.
  - SEND stays in SEND on out_valid & out_ready & !out_last, with cnt <= cnt+1.
  - SEND -> IDLE on out_valid & out_ready & out_last.
- Latency: first beat is valid on the cycle after acceptance. No combinational path from in_valid to out_valid, or from out_ready to in_ready.
- No back-to-back overlap: the next bundle is accepted no earlier than the cycle after the last beat transfers (one idle cycle minimum between bundles).
- out_cols is a pure function of the buffer and cnt: column c = cnt*COLS + k maps to 4*j + r <- buffer[j*Nbits + r*(Nbits/4) + c].
- out_idx = cnt; out_last = (state==SEND) & (cnt == Nbits/(4*COLS) - 1).
- Stall: with out_valid=1 and out_ready=0, out_cols, out_idx and out_last hold stable. in_valid is ignored in SEND.
- Zeroization (masking hygiene): on the last-beat transfer the buffer is cleared to 0. In IDLE, out_cols is driven 0, never stale shares.
- Counter wraps to 0 only via re-acceptance; it never counts past the last beat.
- Reset (rst_n=0 at a clock edge), including mid-transfer:
  - state=IDLE, cnt=0, buffer=0.
  - Outputs: in_ready=1 the cycle after reset deasserts (0 while in reset), out_valid=0, out_last=0, out_idx=0, out_cols=0.
  - Partial transfer is discarded.

Optional Feature:
- Macro: BUNDLE2COLS_STREAM_ABORT_EN.
- Enabled: adds input port abort (1 bit). abort=1 in SEND at a clock edge forces IDLE, clears buffer and cnt, and suppresses that cycle's beat transfer (abort wins over out_ready). abort in IDLE has no effect and does not block acceptance.
- Disabled: port absent; a transfer can only be ended by the last beat or by reset.

Test Plan:
- Nbits=128, d=1, COLS=1; bundle_in=128'h1; out_ready=1 -> 32 beats, idx 0..31; beat 0 out_cols=4'h1, all other beats 0; out_last only on idx 31; in_ready returns 1 the cycle after.
- Same config; bundle_in with bits 32, 64, 96 and 31 set -> beat 0 = 4'hE, beat 31 = 4'h1, all others 0.
- d=2, COLS=2, Nbits=128; share0=128'h1, share1=bit 127 set -> beat 0 out_cols=16'h0001; beat 15 out_cols=16'h8000 (column 31, share 1, row 3); 16 beats total.
- Backpressure: toggle out_ready 1,0,0,1 during beat 5 -> out_cols/out_idx held for 3 cycles, no beat skipped or duplicated; in_valid pulses during SEND ignored.
- Assert rst_n=0 at beat 10 -> next cycle out_valid=0, out_cols=0, in_ready=1 after release; a new bundle then restarts at idx 0.
- With BUNDLE2COLS_STREAM_ABORT_EN: abort with out_ready=1 at beat 3 -> beat 3 not counted, IDLE next cycle, buffer zero, and a new bundle accepted on the following in_valid.
